// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multi-cycle MIPS datapath, with memory
//            wait-state timeout and illegal-opcode trapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
  parameter int MEM_TIMEOUT     = 15,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] op_alu,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_LW    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_WB_I     = 4'd11,
    S_IDLE     = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [7:0] c_WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait;
  logic       r_illegal;
  logic       r_bus_err;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_legal;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A ready on the limit cycle still completes normally.
  assign w_timeout   = w_mem_state && !mem_ready && (r_wait == c_WAIT_LIMIT);
  assign w_legal     = (opcode == c_OP_RTYPE) || (opcode == c_OP_LW) || (opcode == c_OP_SW) ||
                       (opcode == c_OP_BEQ) || (opcode == c_OP_J) || (opcode == c_OP_ADDI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_wait <= (w_mem_state && !mem_ready && !w_timeout) ? r_wait + 8'd1 : 8'd0;
      if (w_timeout) begin
        r_state   <= S_TRAP;
        r_bus_err <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE:   r_state <= S_FETCH;
          S_FETCH:  if (mem_ready) r_state <= S_DECODE;
          S_DECODE: begin
            case (opcode)
              c_OP_RTYPE:       r_state <= S_EXEC_R;
              c_OP_LW, c_OP_SW: r_state <= S_MEM_ADDR;
              c_OP_BEQ:         r_state <= S_BRANCH;
              c_OP_J:           r_state <= S_JUMP;
              c_OP_ADDI:        r_state <= S_EXEC_I;
              default: begin
                if (TRAP_ON_ILLEGAL) begin
                  r_state   <= S_TRAP;
                  r_illegal <= 1'b1;
                end else begin
                  r_state <= S_FETCH;
                end
              end
            endcase
          end
          S_MEM_ADDR: r_state <= (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
          S_MEM_RD:   if (mem_ready) r_state <= S_WB_LW;
          S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
          S_EXEC_R:   r_state <= S_WB_R;
          S_EXEC_I:   r_state <= S_WB_I;
          S_WB_R, S_WB_LW, S_WB_I, S_BRANCH, S_JUMP: r_state <= S_FETCH;
          S_TRAP:     r_state <= S_TRAP;
          default:    r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    op_alu        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        instr_done = !w_legal && !TRAP_ON_ILLEGAL;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        op_alu    = 2'b10;
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        op_alu        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_op = r_illegal;
  assign bus_error  = r_bus_err;
  assign state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed bench for multicycle_control; two instances (trap on /
//            trap off) run against a behavioural model plus literal checks.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_control;

  localparam int TO = 4;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08, OP_ILL = 6'h3f;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] a_op_alu, a_src_b, a_pc_src, b_op_alu, b_src_b, b_pc_src;
  logic a_src_a, a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rd, a_m2r, a_rw, a_done, a_ill, a_bus;
  logic b_src_a, b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rd, b_m2r, b_rw, b_done, b_ill, b_bus;
  logic [3:0] a_state, b_state;

  multicycle_control #(.MEM_TIMEOUT(TO), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .op_alu(a_op_alu), .alu_src_a(a_src_a), .alu_src_b(a_src_b), .pc_source(a_pc_src),
    .pc_write(a_pcw), .pc_write_cond(a_pcwc), .i_or_d(a_iord), .mem_read(a_mr),
    .mem_write(a_mw), .ir_write(a_irw), .reg_dst(a_rd), .mem_to_reg(a_m2r),
    .reg_write(a_rw), .instr_done(a_done), .illegal_op(a_ill), .bus_error(a_bus),
    .state(a_state));

  multicycle_control #(.MEM_TIMEOUT(TO), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .op_alu(b_op_alu), .alu_src_a(b_src_a), .alu_src_b(b_src_b), .pc_source(b_pc_src),
    .pc_write(b_pcw), .pc_write_cond(b_pcwc), .i_or_d(b_iord), .mem_read(b_mr),
    .mem_write(b_mw), .ir_write(b_irw), .reg_dst(b_rd), .mem_to_reg(b_m2r),
    .reg_write(b_rw), .instr_done(b_done), .illegal_op(b_ill), .bus_error(b_bus),
    .state(b_state));

  logic [21:0] obs_a, obs_b;
  assign obs_a = {a_state, a_op_alu, a_src_a, a_src_b, a_pc_src, a_pcw, a_pcwc, a_iord,
                  a_mr, a_mw, a_irw, a_rd, a_m2r, a_rw, a_done, a_ill, a_bus};
  assign obs_b = {b_state, b_op_alu, b_src_a, b_src_b, b_pc_src, b_pcw, b_pcwc, b_iord,
                  b_mr, b_mw, b_irw, b_rd, b_m2r, b_rw, b_done, b_ill, b_bus};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st[2];
  int m_waited[2];
  bit m_ill[2];
  bit m_bus[2];
  bit m_is_mem;

  function automatic bit known_op(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  function automatic int after_decode(input logic [5:0] op, input bit trap_ill);
    if (op == OP_R) return 6;
    if (op == OP_LW || op == OP_SW) return 2;
    if (op == OP_BEQ) return 8;
    if (op == OP_J) return 9;
    if (op == OP_ADDI) return 10;
    return trap_ill ? 15 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 14; m_waited[i] = 0; m_ill[i] = 0; m_bus[i] = 0;
      end else begin
        m_is_mem = (m_st[i] == 0) || (m_st[i] == 3) || (m_st[i] == 5);
        if (m_is_mem && !mem_ready && (m_waited[i] + 1 >= TO)) begin
          m_st[i] = 15; m_bus[i] = 1; m_waited[i] = 0;
        end else begin
          m_waited[i] = (m_is_mem && !mem_ready) ? m_waited[i] + 1 : 0;
          case (m_st[i])
            14: m_st[i] = 0;
            0:  if (mem_ready) m_st[i] = 1;
            1: begin
              if (!known_op(opcode) && i == 0) m_ill[i] = 1;
              m_st[i] = after_decode(opcode, i == 0);
            end
            2:  m_st[i] = (opcode == OP_LW) ? 3 : 5;
            3:  if (mem_ready) m_st[i] = 4;
            5:  if (mem_ready) m_st[i] = 0;
            6:  m_st[i] = 7;
            10: m_st[i] = 11;
            4, 7, 8, 9, 11: m_st[i] = 0;
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic [21:0] expect_vec(input int st, input logic rdy, input bit trap_ill,
                                             input logic [5:0] op, input bit ill, input bit bus);
    logic [1:0] opa, sb, ps;
    logic sa, pw, pwc, iod, mr, mw, irw, rd, m2r, rw, done;
    opa = 0; sb = 0; ps = 0;
    sa = 0; pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; done = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
      1:  begin sb = 2'b11; done = !known_op(op) && !trap_ill; end
      2, 10: begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iod = 1; done = rdy; end
      6:  begin sa = 1; opa = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin sa = 1; opa = 2'b01; pwc = 1; ps = 2'b01; done = 1; end
      9:  begin pw = 1; ps = 2'b10; done = 1; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {4'(st), opa, sa, sb, ps, pw, pwc, iod, mr, mw, irw, rd, m2r, rw, done, ill, bus};
  endfunction

  always @(negedge clk) begin
    chk("model_a", {10'd0, obs_a}, {10'd0, expect_vec(m_st[0], mem_ready, 1'b1, opcode, m_ill[0], m_bus[0])});
    chk("model_b", {10'd0, obs_b}, {10'd0, expect_vec(m_st[1], mem_ready, 1'b0, opcode, m_ill[1], m_bus[1])});
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [5:0] op, input logic rdy, input int sa, input int sb);
    @(posedge clk);
    #1;
    opcode = op;
    mem_ready = rdy;
    @(negedge clk);
    chk("state_a", {28'd0, a_state}, sa);
    chk("state_b", {28'd0, b_state}, sb);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_state_a", {28'd0, a_state}, 14);
    chk("rst_outs_a", {14'd0, obs_a[17:0]}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_a", {28'd0, a_state}, 14);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, a_state}, 14);
    chk("reset_outs", {14'd0, obs_a[17:0]}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; opcode = OP_R; mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_rel", {28'd0, a_state}, 14);

    // R-type
    cyc(OP_R, 1, 0, 0);  chk("fetch_pcw", a_pcw, 1); chk("fetch_irw", a_irw, 1);
    cyc(OP_R, 1, 1, 1);  chk("decode_srcb", a_src_b, 3);
    cyc(OP_R, 1, 6, 6);  chk("execr_alu", a_op_alu, 2); chk("execr_done", a_done, 0);
    cyc(OP_R, 1, 7, 7);  chk("wbr_rw_rd", {a_rw, a_rd, a_done}, 3'b111);

    // lw with 3 wait cycles; ready on the limit cycle must still win
    cyc(OP_LW, 1, 0, 0);
    cyc(OP_LW, 1, 1, 1);
    cyc(OP_LW, 1, 2, 2); chk("memaddr_src", {a_src_a, a_src_b}, 3'b110);
    cyc(OP_LW, 0, 3, 3); chk("memrd_strobe1", {a_mr, a_iord}, 2'b11);
    cyc(OP_LW, 0, 3, 3);
    cyc(OP_LW, 0, 3, 3); chk("memrd_strobe3", {a_mr, a_iord}, 2'b11);
    cyc(OP_LW, 1, 3, 3);
    cyc(OP_LW, 1, 4, 4); chk("wblw", {a_rw, a_m2r, a_done}, 3'b111); chk("lw_no_bus", a_bus, 0);

    // sw with one wait cycle
    cyc(OP_SW, 1, 0, 0);
    cyc(OP_SW, 1, 1, 1);
    cyc(OP_SW, 1, 2, 2);
    cyc(OP_SW, 0, 5, 5); chk("memwr_wait", {a_mw, a_iord, a_done}, 3'b110);
    cyc(OP_SW, 1, 5, 5); chk("memwr_done", {a_mw, a_done}, 2'b11);

    // beq, j, addi
    cyc(OP_BEQ, 1, 0, 0);
    cyc(OP_BEQ, 1, 1, 1);
    cyc(OP_BEQ, 1, 8, 8); chk("branch", {a_op_alu, a_pcwc, a_pc_src, a_src_a}, 6'b01_1_01_1);
    cyc(OP_J, 1, 0, 0);
    cyc(OP_J, 1, 1, 1);
    cyc(OP_J, 1, 9, 9);   chk("jump", {a_pcw, a_pc_src}, 3'b110);
    cyc(OP_ADDI, 1, 0, 0);
    cyc(OP_ADDI, 1, 1, 1);
    cyc(OP_ADDI, 1, 10, 10);
    cyc(OP_ADDI, 1, 11, 11); chk("wbi", {a_rw, a_rd, a_done}, 3'b101);

    // illegal opcode: a traps, b retires as NOP
    cyc(OP_ILL, 1, 0, 0);
    cyc(OP_ILL, 1, 1, 1); chk("ill_done_b", b_done, 1); chk("ill_done_a", a_done, 0);
    cyc(OP_ILL, 1, 15, 0); chk("ill_flag_a", a_ill, 1); chk("ill_flag_b", b_ill, 0);
    cyc(OP_R, 1, 15, 1); chk("ill_sticky", a_ill, 1);

    // FETCH timeout
    do_reset();
    chk("ill_cleared", a_ill, 0);
    cyc(OP_R, 0, 0, 0); chk("fetch_wait_strobe", {a_mr, a_pcw, a_irw}, 3'b100);
    cyc(OP_R, 0, 0, 0);
    cyc(OP_R, 0, 0, 0);
    cyc(OP_R, 0, 0, 0);
    cyc(OP_R, 0, 15, 15); chk("timeout_bus", a_bus, 1); chk("timeout_strobes", {a_mr, a_mw, a_ill}, 3'b000);

    // ready on the fourth cycle avoids the timeout
    do_reset();
    chk("bus_cleared", a_bus, 0);
    cyc(OP_R, 0, 0, 0);
    cyc(OP_R, 0, 0, 0);
    cyc(OP_R, 0, 0, 0);
    cyc(OP_R, 1, 0, 0);
    cyc(OP_R, 1, 1, 1); chk("late_ready_no_bus", a_bus, 0);
    cyc(OP_R, 1, 6, 6);
    cyc(OP_R, 1, 7, 7);

    // asynchronous reset in the middle of WB_LW
    cyc(OP_LW, 1, 0, 0);
    cyc(OP_LW, 1, 1, 1);
    cyc(OP_LW, 1, 2, 2);
    cyc(OP_LW, 1, 3, 3);
    cyc(OP_LW, 1, 4, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", {28'd0, a_state}, 14);
    chk("async_outs", {14'd0, obs_a[17:0]}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("async_rel", {28'd0, a_state}, 14);
    cyc(OP_R, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences one shared ALU, the unified instruction/data memory, the register file and the PC through fetch, decode, execute, memory and writeback steps. It drives the 2-bit ALU-operation code consumed by the ALU-control decoder, plus all datapath mux selects and write enables. It adds memory wait-state handling with a timeout, and illegal-opcode trapping.

Parameters:
MEM_TIMEOUT, 15, maximum consecutive cycles a memory state may wait on mem_ready before bus error (1..255)
TRAP_ON_ILLEGAL, 1, 1: unsupported opcode enters TRAP; 0: treated as NOP (DECODE -> FETCH)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  instruction[31:26] from the instruction register
mem_ready  input  1  memory completes the access this cycle
op_alu  output  2  00 add, 01 subtract, 10 use funct field
alu_src_a  output  1  0 PC, 1 register A
alu_src_b  output  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2
pc_source  output  2  00 ALU result, 01 ALUOut register, 10 jump target
pc_write  output  1  unconditional PC write
pc_write_cond  output  1  PC write when ALU zero (AND done in datapath)
i_or_d  output  1  memory address: 0 PC, 1 ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
reg_dst  output  1  0 rt, 1 rd
mem_to_reg  output  1  0 ALUOut, 1 memory data register
reg_write  output  1  register file write
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_op  output  1  sticky; set on entering TRAP via bad opcode
bus_error  output  1  sticky; set on entering TRAP via timeout
state  output  4  current state code (debug)

Behaviour:
- State codes: IDLE=14, FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, WB_LW=4, MEM_WR=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, EXEC_I=10, WB_I=11, TRAP=15.
- Reset (rst_n low, asynchronous): state=IDLE, wait counter=0, illegal_op=0, bus_error=0. All outputs are 0. IDLE -> FETCH on the next clock edge.
- Outputs decode from the state register, except that pc_write and ir_write in FETCH are gated by mem_ready. Any output not listed for a state is 0:
  FETCH: mem_read=1, alu_src_b=01, pc_write=ir_write=mem_ready.
  DECODE: alu_src_b=11.
  MEM_ADDR and EXEC_I: alu_src_a=1, alu_src_b=10.
  MEM_RD: mem_read=1, i_or_d=1.
  MEM_WR: mem_write=1, i_or_d=1.
  WB_LW: reg_write=1, mem_to_reg=1.
  EXEC_R: alu_src_a=1, op_alu=10.
  WB_R: reg_write=1, reg_dst=1.
  BRANCH: alu_src_a=1, op_alu=01, pc_write_cond=1, pc_source=01.
  JUMP: pc_write=1, pc_source=10.
  WB_I: reg_write=1.
- Transitions:
  FETCH -> DECODE when mem_ready=1.
  DECODE by opcode: 000000 -> EXEC_R, 100011 or 101011 -> MEM_ADDR, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> EXEC_I. Any other opcode -> TRAP (sets illegal_op) if TRAP_ON_ILLEGAL=1, else -> FETCH.
  MEM_ADDR -> MEM_RD (100011) or MEM_WR (101011). The opcode is stable because ir_write=0 outside FETCH.
  MEM_RD -> WB_LW on mem_ready. MEM_WR -> FETCH on mem_ready.
  EXEC_R -> WB_R. EXEC_I -> WB_I.
  WB_R, WB_LW, WB_I, BRANCH, JUMP -> FETCH.
  TRAP -> TRAP until reset.
- instr_done=1 for the single cycle in WB_R, WB_LW, WB_I, BRANCH, JUMP, or MEM_WR with mem_ready=1, and in DECODE for an illegal opcode when TRAP_ON_ILLEGAL=0.
- Wait counter (8-bit):
  Increments on each cycle in FETCH, MEM_RD or MEM_WR with mem_ready=0. Clears to 0 when mem_ready=1 or on leaving those states.
  If mem_ready=0 and counter==MEM_TIMEOUT-1: next state TRAP, bus_error set. So the maximum wait is MEM_TIMEOUT cycles.
  If mem_ready=1 on the same cycle the limit is reached, mem_ready wins: normal transition, no error.
- Strobes mem_read and mem_write stay asserted for the whole wait period.
- Reset asserted mid-instruction aborts immediately to IDLE, and sticky flags clear. Only a reset clears the sticky flags.

Test Plan:
- Reset then R-type: opcode=000000, mem_ready=1 always -> states 14,0,1,6,7,0. op_alu=10 in EXEC_R, reg_write=reg_dst=1 in WB_R, instr_done pulses once. Retire takes 4 cycles.
- lw with 3 wait cycles in MEM_RD: opcode=100011 -> 0,1,2,3,3,3,3,4,0. mem_read=i_or_d=1 held through all MEM_RD cycles, mem_to_reg=1 in WB_LW.
- sw and beq: opcode=101011 -> MEM_WR with mem_write=1, then FETCH. opcode=000100 -> BRANCH with op_alu=01, pc_write_cond=1, pc_source=01, then FETCH.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 FETCH cycles, bus_error=1, all strobes 0. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no error.
- Illegal opcode 111111: TRAP_ON_ILLEGAL=1 -> TRAP, illegal_op=1 sticky. TRAP_ON_ILLEGAL=0 -> DECODE to FETCH, instr_done=1, no flag.
- Async reset pulsed low mid-WB_LW (between clock edges) -> outputs immediately 0, state=14. FETCH follows after rst_n releases.
